// File: rtl/rv_pipe_ctrl_if.sv
// Control bundle between the pipeline stages and the hazard controller.
// master = pipeline side, slave = controller side.
interface rv_pipe_ctrl_if;
  logic        f_valid_i;
  logic        d_load_hazard_i;
  logic        x_valid_i;
  logic        x_branch_taken_i;
  logic        x_trap_i;
  logic        x_mc_start_i;
  logic        x_mc_done_i;
  logic        dm_busy_i;
  logic        perf_clr_i;
  logic        f_stall_o;
  logic        d_stall_o;
  logic        x_stall_o;
  logic        d_kill_o;
  logic        x_kill_o;
  logic        f_redirect_o;
  logic [2:0]  state_o;
  logic [15:0] stall_cnt_o;

  modport master (
    output f_valid_i, d_load_hazard_i, x_valid_i,
    output x_branch_taken_i, x_trap_i,
    output x_mc_start_i, x_mc_done_i,
    output dm_busy_i, perf_clr_i,
    input  f_stall_o, d_stall_o, x_stall_o,
    input  d_kill_o, x_kill_o, f_redirect_o,
    input  state_o, stall_cnt_o
  );

  modport slave (
    input  f_valid_i, d_load_hazard_i, x_valid_i,
    input  x_branch_taken_i, x_trap_i,
    input  x_mc_start_i, x_mc_done_i,
    input  dm_busy_i, perf_clr_i,
    output f_stall_o, d_stall_o, x_stall_o,
    output d_kill_o, x_kill_o, f_redirect_o,
    output state_o, stall_cnt_o
  );
endinterface

// File: rtl/rv_pipe_ctrl.sv
// Pipeline hazard controller: stalls, kills, redirects for a 3-stage core.
// Outputs are combinational from state and inputs.
module rv_pipe_ctrl #(
  parameter int G_KILL_CYCLES = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  rv_pipe_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    LOAD_BUB = 3'd1,
    MC_WAIT  = 3'd2,
    KILL     = 3'd3
  } state_t;

  localparam logic [2:0] KLOAD = 3'(G_KILL_CYCLES - 1);
  localparam bit MULTI = (G_KILL_CYCLES > 1);

  state_t      state, state_nxt;
  logic [2:0]  kcnt, kcnt_nxt;
  logic [15:0] cnt;
  logic        fs, ds, xs, dk, xk, fr;
  logic        redirect, mc_req, done;

  assign redirect = bus.x_valid_i &
                    (bus.x_branch_taken_i | bus.x_trap_i);
  assign mc_req   = bus.x_valid_i & bus.x_mc_start_i;
  assign done     = bus.x_mc_done_i;

  always_comb begin
    fs        = 1'b0;
    ds        = 1'b0;
    xs        = 1'b0;
    dk        = 1'b0;
    xk        = 1'b0;
    fr        = 1'b0;
    state_nxt = state;
    kcnt_nxt  = kcnt;
    if (bus.dm_busy_i) begin
      fs = 1'b1;
      ds = 1'b1;
      xs = 1'b1;
    end else if (redirect &&
                 (state == RUN || state == KILL)) begin
      fr        = 1'b1;
      dk        = 1'b1;
      kcnt_nxt  = KLOAD;
      state_nxt = MULTI ? KILL : RUN;
    end else begin
      case (state)
        RUN: begin
          // a started op that finishes the same cycle needs no stall
          if (mc_req) begin
            if (!done) begin
              fs        = 1'b1;
              ds        = 1'b1;
              xs        = 1'b1;
              xk        = 1'b1;
              state_nxt = MC_WAIT;
            end
          end else if (bus.d_load_hazard_i) begin
            fs        = 1'b1;
            ds        = 1'b1;
            xk        = 1'b1;
            state_nxt = LOAD_BUB;
          end
        end
        LOAD_BUB: state_nxt = RUN;
        MC_WAIT: begin
          if (!done) begin
            fs = 1'b1;
            ds = 1'b1;
            xs = 1'b1;
            xk = 1'b1;
          end else begin
            state_nxt = RUN;
          end
        end
        KILL: begin
          dk       = 1'b1;
          kcnt_nxt = kcnt - 3'd1;
          if (kcnt <= 3'd1) state_nxt = RUN;
        end
        default: begin
          state_nxt = RUN;
          kcnt_nxt  = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= RUN;
      kcnt  <= 3'd0;
    end else begin
      state <= state_nxt;
      kcnt  <= kcnt_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= 16'd0;
    end else if (bus.perf_clr_i) begin
      cnt <= 16'd0;
    end else if (ds && bus.f_valid_i && cnt != 16'hFFFF) begin
      cnt <= cnt + 16'd1;
    end
  end

  // inputs may be active during reset; outputs must still read idle
  assign bus.f_stall_o    = rst_n_i & fs;
  assign bus.d_stall_o    = rst_n_i & ds;
  assign bus.x_stall_o    = rst_n_i & xs;
  assign bus.d_kill_o     = rst_n_i & dk;
  assign bus.x_kill_o     = rst_n_i & xk;
  assign bus.f_redirect_o = rst_n_i & fr;
  assign bus.state_o      = state;
  assign bus.stall_cnt_o  = cnt;

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Scoreboard bench for rv_pipe_ctrl.
// Expected outputs queued on drive, popped when sampled.
module tb_rv_pipe_ctrl;

  localparam logic [8:0] FV   = 9'd1;
  localparam logic [8:0] LH   = 9'd2;
  localparam logic [8:0] XV   = 9'd4;
  localparam logic [8:0] BR   = 9'd8;
  localparam logic [8:0] TR   = 9'd16;
  localparam logic [8:0] MS   = 9'd32;
  localparam logic [8:0] MD   = 9'd64;
  localparam logic [8:0] BUSY = 9'd128;
  localparam logic [8:0] CLR  = 9'd256;

  typedef struct {
    logic [8:0]  o;
    logic [15:0] c;
    string       tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  logic [15:0] mcnt;
  exp_t q[$];

  rv_pipe_ctrl_if bus ();

  rv_pipe_ctrl #(.G_KILL_CYCLES(2)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  function automatic logic [8:0] ex(
    input logic fs, input logic ds, input logic xs,
    input logic dk, input logic xk, input logic fr,
    input logic [2:0] st);
    return {fs, ds, xs, dk, xk, fr, st};
  endfunction

  function automatic logic [8:0] outs();
    return {bus.f_stall_o, bus.d_stall_o, bus.x_stall_o,
            bus.d_kill_o, bus.x_kill_o, bus.f_redirect_o,
            bus.state_o};
  endfunction

  task automatic drive(input logic [8:0] v);
    bus.f_valid_i        = v[0];
    bus.d_load_hazard_i  = v[1];
    bus.x_valid_i        = v[2];
    bus.x_branch_taken_i = v[3];
    bus.x_trap_i         = v[4];
    bus.x_mc_start_i     = v[5];
    bus.x_mc_done_i      = v[6];
    bus.dm_busy_i        = v[7];
    bus.perf_clr_i       = v[8];
  endtask

  // one clock: drive after the edge, sample before the next edge
  task automatic step(input string tag,
                      input logic [8:0] v,
                      input logic [8:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    drive(v);
    q.push_back('{o: e, c: mcnt, tag: tag});
    #3;
    x = q.pop_front();
    chk(x.tag, 32'(outs()), 32'(x.o));
    chk({x.tag, "_cnt"}, 32'(bus.stall_cnt_o), 32'(x.c));
    if (v[8]) mcnt = 16'd0;
    else if (e[7] && v[0] && mcnt != 16'hFFFF) mcnt++;
  endtask

  localparam logic [8:0] IDLE = 9'd0;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    mcnt   = 16'd0;
    drive(BUSY | LH | XV | BR);
    rst_n = 1'b0;
    #12;
    chk("rst_outs", 32'(outs()), 32'd0);
    chk("rst_cnt", 32'(bus.stall_cnt_o), 32'd0);
    drive(IDLE);
    @(negedge clk);
    rst_n = 1'b1;

    step("idle", IDLE, ex(0,0,0,0,0,0,0));
    step("lh0", FV|LH, ex(1,1,0,0,1,0,0));
    step("lh1", FV|LH, ex(0,0,0,0,0,0,1));
    step("lh2", FV|LH, ex(1,1,0,0,1,0,0));
    step("lh3", IDLE, ex(0,0,0,0,0,0,1));
    step("lh4", IDLE, ex(0,0,0,0,0,0,0));
    step("clr", CLR, ex(0,0,0,0,0,0,0));

    step("br0", XV|BR, ex(0,0,0,1,0,1,0));
    step("br1", IDLE, ex(0,0,0,1,0,0,3));
    step("br2", IDLE, ex(0,0,0,0,0,0,0));

    step("mc0", FV|XV|MS, ex(1,1,1,0,1,0,0));
    for (int i = 1; i < 4; i++)
      step("mcw", FV|XV, ex(1,1,1,0,1,0,2));
    step("mc4", FV|XV|MD, ex(0,0,0,0,0,0,2));
    step("mc5", IDLE, ex(0,0,0,0,0,0,0));
    chk("mc_cnt", 32'(bus.stall_cnt_o), 32'd4);

    step("fz0", XV|BR, ex(0,0,0,1,0,1,0));
    step("fz1", BUSY, ex(1,1,1,0,0,0,3));
    step("fz2", BUSY, ex(1,1,1,0,0,0,3));
    step("fz3", IDLE, ex(0,0,0,1,0,0,3));
    step("fz4", IDLE, ex(0,0,0,0,0,0,0));

    step("sim0", FV|XV|BR|MS|LH, ex(0,0,0,1,0,1,0));
    step("sim1", IDLE, ex(0,0,0,1,0,0,3));
    step("sim2", IDLE, ex(0,0,0,0,0,0,0));

    step("rk0", XV|BR, ex(0,0,0,1,0,1,0));
    step("rk1", XV|TR, ex(0,0,0,1,0,1,3));
    step("rk2", IDLE, ex(0,0,0,1,0,0,3));
    step("rk3", IDLE, ex(0,0,0,0,0,0,0));

    step("mcd0", FV|XV|MS|MD, ex(0,0,0,0,0,0,0));
    step("mcd1", IDLE, ex(0,0,0,0,0,0,0));

    step("mbr0", XV|MS, ex(1,1,1,0,1,0,0));
    step("mbr1", XV|BR, ex(1,1,1,0,1,0,2));
    step("mbr2", XV|MD, ex(0,0,0,0,0,0,2));
    step("mbr3", IDLE, ex(0,0,0,0,0,0,0));

    step("busy0", BUSY|XV|BR, ex(1,1,1,0,0,0,0));
    step("busy1", IDLE, ex(0,0,0,0,0,0,0));

    step("ar0", XV|MS, ex(1,1,1,0,1,0,0));
    @(posedge clk);
    #1;
    drive(XV|MS);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_outs", 32'(outs()), 32'd0);
    chk("ar_cnt", 32'(bus.stall_cnt_o), 32'd0);
    mcnt = 16'd0;
    drive(IDLE);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("ar1", FV|LH, ex(1,1,0,0,1,0,0));
    step("ar2", IDLE, ex(0,0,0,0,0,0,1));

    step("sat0", FV|XV|MS|CLR, ex(1,1,1,0,1,0,0));
    @(posedge clk);
    #1;
    drive(FV|XV);
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_a", 32'(bus.stall_cnt_o), 32'hFFFF);
    @(posedge clk);
    #1;
    chk("sat_b", 32'(bus.stall_cnt_o), 32'hFFFF);
    chk("sat_st", 32'(bus.state_o), 32'd2);
    drive(FV|XV|CLR);
    @(posedge clk);
    #1;
    chk("sat_clr", 32'(bus.stall_cnt_o), 32'd0);
    drive(XV|MD);
    @(posedge clk);
    #1;
    drive(IDLE);
    #3;
    chk("sat_end", 32'(outs()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rv_pipe_ctrl.md
RV_PIPE_CTRL -- requirements
Module: rv_pipe_ctrl

Interface
REQ-001 SHALL have parameter G_KILL_CYCLES, default 2, giving the number of cycles d_kill_o is held after a redirect (legal range 1..7).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_i, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port f_valid_i, input, 1, fetch stage presents a valid instruction.
REQ-005 SHALL have port d_load_hazard_i, input, 1, decode reports load-use hazard against the instruction in X.
REQ-006 SHALL have port x_valid_i, input, 1, X stage holds a valid instruction.
REQ-007 SHALL have port x_branch_taken_i, input, 1, taken branch/jump resolved in X.
REQ-008 SHALL have port x_trap_i, input, 1, exception/trap raised in X.
REQ-009 SHALL have port x_mc_start_i, input, 1, X begins a multicycle operation (mul/div/CSR).
REQ-010 SHALL have port x_mc_done_i, input, 1, the multicycle operation completes this cycle.
REQ-011 SHALL have port dm_busy_i, input, 1, data memory not ready; whole pipe freezes.
REQ-012 SHALL have port perf_clr_i, input, 1, synchronous clear of the stall counter.
REQ-013 SHALL have ports f_stall_o, d_stall_o, x_stall_o, output, 1 each, hold the respective stage.
REQ-014 SHALL have ports d_kill_o, x_kill_o, output, 1 each, invalidate the instruction entering X / W.
REQ-015 SHALL have port f_redirect_o, output, 1, fetch loads the new target PC this cycle.
REQ-016 SHALL have port state_o, output, 3, current FSM state encoding (debug).
REQ-017 SHALL have port stall_cnt_o, output, 16, saturating count of cycles with d_stall_o=1.

Function
REQ-018 SHALL implement states RUN=0, LOAD_BUB=1, MC_WAIT=2, KILL=3; other encodings SHALL return to RUN next cycle with all outputs as in RUN-idle.
REQ-019 Outputs SHALL be combinational from state and inputs; no added latency.
REQ-020 Priority per cycle SHALL be: dm_busy_i > redirect (x_valid_i & (x_branch_taken_i | x_trap_i)) > x_mc_start_i > d_load_hazard_i.
REQ-021 dm_busy_i=1 in any state: all three stalls=1, both kills=0, f_redirect_o=0, state and kill counter held.
REQ-022 RUN, redirect: f_redirect_o=1, d_kill_o=1, x_kill_o=0, no stalls; load kill counter with G_KILL_CYCLES-1; next state KILL if G_KILL_CYCLES>1, else RUN.
REQ-023 KILL: d_kill_o=1, counter decrements each cycle; at counter 1 next state RUN; a new redirect in KILL restarts per REQ-022.
REQ-024 RUN, x_valid_i & x_mc_start_i & !x_mc_done_i: f/d/x stalls=1, x_kill_o=1; next MC_WAIT. Same-cycle x_mc_done_i: no stall, stay RUN.
REQ-025 MC_WAIT: f/d/x stalls=1 and x_kill_o=1 while x_mc_done_i=0; on x_mc_done_i=1 all stalls=0, x_kill_o=0, next RUN; redirect evaluated only after return to RUN.
REQ-026 RUN, d_load_hazard_i=1 (no higher event): f_stall_o=d_stall_o=1, x_stall_o=0, x_kill_o=1 (one bubble); next LOAD_BUB.
REQ-027 LOAD_BUB: stalls=0, kills=0, d_load_hazard_i ignored; next RUN (guarantees exactly one bubble per hazard).
REQ-028 f_valid_i=0 SHALL NOT suppress stalls or kills; it only gates counting in REQ-029.
REQ-029 stall_cnt_o SHALL increment when d_stall_o=1 and f_valid_i=1, saturate at 16'hFFFF; perf_clr_i forces 0, with priority over increment.

Reset
REQ-030 While rst_n_i=0: state=RUN, kill counter=0, stall_cnt_o=0, all stall/kill/redirect outputs=0, state_o=0, independent of clock.
REQ-031 Reset asserted mid-MC_WAIT or mid-KILL SHALL abort immediately; first cycle after release behaves as RUN.

Verification
REQ-032 Load hazard: d_load_hazard_i=1 held 3 cycles in RUN -> f/d stall and x_kill=1 cycle 0 only, state 0->1->0, second hazard acted on in cycle 2.
REQ-033 Branch: x_valid_i=1, x_branch_taken_i=1 one cycle, G_KILL_CYCLES=2 -> f_redirect=1 cycle 0, d_kill=1 cycles 0-1, state 0->3->0.
REQ-034 Multicycle: x_mc_start_i cycle 0, x_mc_done_i cycle 4 -> f/d/x stall=1 cycles 0-3, released cycle 4, stall_cnt_o=4 with f_valid_i=1.
REQ-035 Freeze: dm_busy_i=1 for 2 cycles during KILL with counter=1 -> all stalls=1, d_kill=0, state stays 3, completes KILL after release.
REQ-036 Simultaneous: redirect + x_mc_start_i + d_load_hazard_i same cycle -> only redirect actions, next state KILL.
REQ-037 Async reset: rst_n_i low between clock edges in MC_WAIT -> outputs 0 and state_o=0 immediately; stall_cnt_o saturation check at 65535 holds value.
